instr_decode_stage: RTL and testbench

- Registered, parametrised instruction-decode pipeline stage sitting between instruction fetch and execute.
- Accepts {pc, instruction} beats over a valid/ready handshake and decodes the opcode into a 2-bit type code with an explicit illegal flag.
- Extracts register fields and a type-dependent immediate/target, holds one decoded beat in an output register, supports flush, and keeps saturating decoded/illegal counters.

---
 rtl/instr_decode_stage.sv | 117 +++++++++++
 tb/tb_instr_decode_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage: valid/ready input, one-entry output register,
// opcode -> type decode with illegal flag, immediate extraction, saturating beat counters.
module instr_decode_stage #(
  parameter int B   = 32,
  parameter int N   = 8,
  parameter int OPW = 6,
  parameter int RW  = 5,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_pc,
  input  logic [B-1:0]  in_instr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_pc,
  output logic [1:0]    out_type,
  output logic          out_illegal,
  output logic [RW-1:0] out_rs,
  output logic [RW-1:0] out_rt,
  output logic [RW-1:0] out_rd,
  output logic [B-1:0]  out_imm,
  output logic [CW-1:0] dec_count,
  output logic [CW-1:0] ill_count
);
  localparam int IW = B - OPW - 2*RW;

  if (!(OPW + 3*RW < B) || OPW < 2) begin : g_bad_params
    $error("instr_decode_stage: illegal field widths (need OPW + 3*RW < B and OPW >= 2)");
  end

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [1:0]    typ;
    logic          ill;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [B-1:0]  imm;
  } beat_t;

  beat_t         beat_q, beat_d, dec;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] dec_count_q, dec_count_d;
  logic [CW-1:0] ill_count_q, ill_count_d;
  logic [OPW-1:0] opcode;
  logic          accept, fire;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // A flushed beat is discarded, so it never counts as delivered.
  assign fire     = out_valid_q && out_ready && !flush;

  always_comb begin
    dec    = '0;
    opcode = in_instr[B-1 -: OPW];
    dec.pc = in_pc;
    dec.rs = in_instr[B-OPW-1 -: RW];
    dec.rt = in_instr[B-OPW-RW-1 -: RW];
    dec.rd = in_instr[B-OPW-2*RW-1 -: RW];
    if (opcode == OPW'(0)) begin
      dec.typ = 2'd0;
    end else if (opcode == OPW'(1)) begin
      dec.typ = 2'd1;
      dec.imm = {{(B-IW){in_instr[IW-1]}}, in_instr[IW-1:0]};
    end else if (opcode == OPW'(2)) begin
      dec.typ = 2'd2;
      dec.imm = {{OPW{1'b0}}, in_instr[B-OPW-1:0]};
    end else begin
      dec.typ = 2'd3;
      dec.ill = 1'b1;
    end
  end

  always_comb begin
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    dec_count_d = dec_count_q;
    ill_count_d = ill_count_q;
    if (accept) begin
      beat_d      = dec;
      out_valid_d = 1'b1;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
    if (fire && dec_count_q != '1) dec_count_d = dec_count_q + CW'(1);
    if (fire && beat_q.ill && ill_count_q != '1) ill_count_d = ill_count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      dec_count_q <= '0;
      ill_count_q <= '0;
    end else begin
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      dec_count_q <= dec_count_d;
      ill_count_q <= ill_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = beat_q.pc;
  assign out_type    = beat_q.typ;
  assign out_illegal = beat_q.ill;
  assign out_rs      = beat_q.rs;
  assign out_rt      = beat_q.rt;
  assign out_rd      = beat_q.rd;
  assign out_imm     = beat_q.imm;
  assign dec_count   = dec_count_q;
  assign ill_count   = ill_count_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: default instance plus a CW=3 instance for saturation.
module tb_instr_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [7:0]  in_pc;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, out_illegal;
  logic [7:0]  out_pc;
  logic [1:0]  out_type;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [31:0] out_imm;
  logic [15:0] dec_count, ill_count;
  logic        in_ready2, out_valid2, out_illegal2;
  logic [7:0]  out_pc2;
  logic [1:0]  out_type2;
  logic [4:0]  out_rs2, out_rt2, out_rd2;
  logic [31:0] out_imm2;
  logic [2:0]  dec_count2, ill_count2;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_type(out_type), .out_illegal(out_illegal), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm), .dec_count(dec_count),
    .ill_count(ill_count));

  instr_decode_stage #(.CW(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_type(out_type2), .out_illegal(out_illegal2), .out_rs(out_rs2),
    .out_rt(out_rt2), .out_rd(out_rd2), .out_imm(out_imm2), .dec_count(dec_count2),
    .ill_count(ill_count2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] pc, input logic [1:0] typ,
                          input logic ill, input logic [31:0] imm);
    chk({tag, ".valid"}, 64'(out_valid), 64'(1));
    chk({tag, ".pc"},    64'(out_pc), 64'(pc));
    chk({tag, ".type"},  64'(out_type), 64'(typ));
    chk({tag, ".ill"},   64'(out_illegal), 64'(ill));
    chk({tag, ".imm"},   64'(out_imm), 64'(imm));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_pc = 8'h44; in_instr = 32'h0422FFFC;
    // Reset with a valid beat presented
    step(); step();
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.pc", 64'(out_pc), 64'(0));
    chk("rst.imm", 64'(out_imm), 64'(0));
    chk("rst.type", 64'(out_type), 64'(0));
    chk("rst.dec", 64'(dec_count), 64'(0));
    chk("rst.ill", 64'(ill_count), 64'(0));
    rst_n = 1'b1; in_valid = 1'b0;
    #1 chk("rst.in_ready", 64'(in_ready), 64'(1));

    // Decode sweep, back-to-back
    in_valid = 1'b1; in_pc = 8'h04; in_instr = 32'h00221820;
    step();
    chk_beat("r", 8'h04, 2'd0, 1'b0, 32'h0);
    chk("r.rs", 64'(out_rs), 64'(1));
    chk("r.rt", 64'(out_rt), 64'(2));
    chk("r.rd", 64'(out_rd), 64'(3));
    in_pc = 8'h08; in_instr = 32'h0422FFFC;
    step();
    chk_beat("i", 8'h08, 2'd1, 1'b0, 32'hFFFFFFFC);
    chk("i.dec", 64'(dec_count), 64'(1));
    in_pc = 8'h0C; in_instr = 32'h08000010;
    step();
    chk_beat("j", 8'h0C, 2'd2, 1'b0, 32'h00000010);
    chk("j.dec", 64'(dec_count), 64'(2));
    in_valid = 1'b0;
    step();
    chk("sweep.valid", 64'(out_valid), 64'(0));
    chk("sweep.dec", 64'(dec_count), 64'(3));

    // Illegal opcode 0x3F with register fields 1/2/3
    in_valid = 1'b1; in_pc = 8'h10; in_instr = 32'hFC221820;
    step();
    chk_beat("ill", 8'h10, 2'd3, 1'b1, 32'h0);
    chk("ill.rs", 64'(out_rs), 64'(1));
    chk("ill.rd", 64'(out_rd), 64'(3));
    chk("ill.cnt_before", 64'(ill_count), 64'(0));
    in_valid = 1'b0;
    step();
    chk("ill.cnt", 64'(ill_count), 64'(1));
    chk("ill.dec", 64'(dec_count), 64'(4));

    // Backpressure: hold beat 0x20 for 5 cycles while 0x24 waits upstream
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 8'h20; in_instr = 32'h04000005;
    step();
    in_pc = 8'h24; in_instr = 32'h08000123;
    for (int k = 0; k < 4; k++) begin
      chk("bp.in_ready", 64'(in_ready), 64'(0));
      chk_beat("bp.hold", 8'h20, 2'd1, 1'b0, 32'h5);
      step();
    end
    chk_beat("bp.hold5", 8'h20, 2'd1, 1'b0, 32'h5);
    chk("bp.dec", 64'(dec_count), 64'(4));
    out_ready = 1'b1;
    #1 chk("bp.in_ready_rel", 64'(in_ready), 64'(1));
    step();
    chk_beat("bp.next", 8'h24, 2'd2, 1'b0, 32'h123);
    chk("bp.dec_next", 64'(dec_count), 64'(5));
    in_valid = 1'b0;
    step();
    chk("bp.drain", 64'(out_valid), 64'(0));
    chk("bp.dec_end", 64'(dec_count), 64'(6));

    // Flush a held beat with out_ready = 1
    in_valid = 1'b1; in_pc = 8'h30; in_instr = 32'h00221820;
    step();
    chk("fl.held", 64'(out_valid), 64'(1));
    in_pc = 8'h34; flush = 1'b1;
    #1 chk("fl.in_ready", 64'(in_ready), 64'(0));
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.valid", 64'(out_valid), 64'(0));
    chk("fl.dec", 64'(dec_count), 64'(6));
    step();
    chk("fl.dec_after", 64'(dec_count), 64'(6));

    // Saturation on the CW=3 instance
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("sat.rst", 64'(dec_count2), 64'(0));
    in_valid = 1'b1; in_instr = 32'h04000001;
    for (int k = 0; k < 10; k++) begin
      in_pc = 8'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat.dec3", 64'(dec_count2), 64'(7));
    chk("sat.dec16", 64'(dec_count), 64'(10));

    // Reset mid-stream
    in_valid = 1'b1;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("mid.valid", 64'(out_valid), 64'(0));
    chk("mid.dec", 64'(dec_count), 64'(0));
    chk("mid.valid3", 64'(out_valid2), 64'(0));
    chk("mid.dec3", 64'(dec_count2), 64'(0));
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
